// File: rtl/display_fetch_pkg.sv
// Shared types and helpers for the display fetch responder: FSM states,
// line geometry helpers and the burst base address function.
package display_fetch_pkg;

  localparam int DEF_ADDR_W    = 22;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MISS_REQ,
    ST_FILL,
    ST_RESPOND,
    ST_ACKED
  } fetch_state_t;

  function automatic int idx_width(input int burst_len);
    return $clog2(burst_len);
  endfunction

  // Byte address bit 0 selects within a word, so the tag starts above the word index.
  function automatic int tag_width(input int addr_w, input int burst_len);
    return addr_w - $clog2(burst_len) - 1;
  endfunction

  function automatic logic [31:0] aligned_base(input logic [31:0] addr, input int burst_len);
    logic [31:0] mask;
    mask = 32'(2 * burst_len) - 32'd1;
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/fetch_line_buffer.sv
// One cached line: a small register file written by the fill beat counter,
// read by word index, plus the line's valid bit and tag with a hit compare.
module fetch_line_buffer #(
  parameter int TAG_W = 19,
  parameter int IDX_W = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_widx,
  input  logic [15:0]      i_wdata,
  input  logic [IDX_W-1:0] i_ridx,
  output logic [15:0]      o_rdata,
  input  logic             i_load_tag,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_set_valid,
  input  logic             i_clr_valid,
  output logic             o_hit
);

  localparam int DEPTH = 1 << IDX_W;

  logic [15:0]      r_mem [DEPTH];
  logic             r_valid;
  logic [TAG_W-1:0] r_tag;

  // Data storage is left unreset; the valid bit alone guards it.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_widx] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else begin
      if (i_clr_valid)      r_valid <= 1'b0;
      else if (i_set_valid) r_valid <= 1'b1;
      if (i_load_tag) r_tag <= i_tag;
    end
  end

  assign o_rdata = r_mem[i_ridx];
  assign o_hit   = r_valid && (r_tag == i_tag);

endmodule

// File: rtl/display_fetch_responder.sv
// Word-read responder for the display file decoder: serves hits from a single
// line buffer and refills it with one aligned RAM burst on a miss.
module display_fetch_responder
  import display_fetch_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              as,
  output logic [15:0]       din,
  output logic              bus_ack,
  input  logic              flush,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_req,
  input  logic              ram_ack,
  input  logic [15:0]       ram_data,
  input  logic              ram_valid,
  output fetch_state_t      o_dbg_state
);

  localparam int IDX_W = idx_width(BURST_LEN);
  localparam int TAG_W = tag_width(ADDR_W, BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BURST_LEN - 1);

  // Handshakes: the decoder holds as until it samples a one-cycle bus_ack;
  // ram_req stays high until sampled with ram_ack, then each ram_valid cycle
  // carries exactly one beat, BURST_LEN beats per burst in ascending order.

  fetch_state_t r_state, w_next;

  logic [15:0]       r_din;
  logic              r_bus_ack;
  logic              r_ram_req;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [IDX_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_idx;
  logic              r_flush_pend;

  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [15:0]      w_rdata;
  logic             w_hit;
  logic             w_miss;
  logic             w_hit_ack;
  logic             w_resp;
  logic             w_beat;
  logic             w_complete;
  logic             w_load_din;
  logic             w_in_miss;

  assign w_tag      = address[ADDR_W-1:IDX_W+1];
  assign w_idx      = address[IDX_W:1];
  assign w_rd_idx   = (r_state == ST_IDLE) ? w_idx : r_idx;
  assign w_load_din = w_hit_ack || w_resp;
  assign w_in_miss  = (r_state == ST_MISS_REQ) || (r_state == ST_FILL);

  fetch_line_buffer #(
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_line (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .i_we        (w_beat),
    .i_widx      (r_count),
    .i_wdata     (ram_data),
    .i_ridx      (w_rd_idx),
    .o_rdata     (w_rdata),
    .i_load_tag  (w_miss),
    .i_tag       (w_tag),
    .i_set_valid (w_complete && !r_flush_pend && !flush),
    .i_clr_valid (flush || w_miss),
    .o_hit       (w_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_miss     = 1'b0;
    w_hit_ack  = 1'b0;
    w_resp     = 1'b0;
    w_beat     = 1'b0;
    w_complete = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (as) begin
          // A flush in the lookup cycle forces the miss path.
          if (w_hit && !flush) begin
            w_hit_ack = 1'b1;
            w_next    = ST_ACKED;
          end else begin
            w_miss = 1'b1;
            w_next = ST_MISS_REQ;
          end
        end
      end
      ST_MISS_REQ: begin
        w_beat = ram_valid;
        if (ram_valid && (r_count == LAST_BEAT)) begin
          w_complete = 1'b1;
          w_next     = ST_RESPOND;
        end else if (ram_ack) begin
          w_next = ST_FILL;
        end
      end
      ST_FILL: begin
        w_beat = ram_valid;
        if (ram_valid && (r_count == LAST_BEAT)) begin
          w_complete = 1'b1;
          w_next     = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        w_resp = 1'b1;
        w_next = ST_ACKED;
      end
      ST_ACKED: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_din        <= '0;
      r_bus_ack    <= 1'b0;
      r_ram_req    <= 1'b0;
      r_ram_addr   <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_bus_ack <= w_load_din;
      if (w_load_din) r_din <= w_rdata;

      if (w_miss) begin
        r_ram_req  <= 1'b1;
        r_ram_addr <= ADDR_W'(aligned_base(32'(address), BURST_LEN));
        r_idx      <= w_idx;
      end else if ((r_state == ST_MISS_REQ) && (ram_ack || w_complete)) begin
        r_ram_req <= 1'b0;
      end

      if (w_beat) r_count <= (r_count == LAST_BEAT) ? '0 : r_count + IDX_W'(1);

      // A flush mid-burst must leave the refilled line invalid.
      if (w_complete)             r_flush_pend <= 1'b0;
      else if (flush && w_in_miss) r_flush_pend <= 1'b1;
    end
  end

  assign din         = r_din;
  assign bus_ack     = r_bus_ack;
  assign ram_req     = r_ram_req;
  assign ram_addr    = r_ram_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_display_fetch_responder.sv
// Directed bench for display_fetch_responder: drivers push expected read data,
// a negedge monitor pops and compares on every bus_ack.
module tb_display_fetch_responder;
  import display_fetch_pkg::*;

  localparam int ADDR_W = 22;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic              as = 1'b0;
  logic              flush = 1'b0;
  logic              ram_ack = 1'b0;
  logic [15:0]       ram_data = '0;
  logic              ram_valid = 1'b0;
  logic [15:0]       din;
  logic              bus_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_req;
  fetch_state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          prev_ack = 1'b0;

  display_fetch_responder #(.ADDR_W(ADDR_W), .BURST_LEN(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .as          (as),
    .din         (din),
    .bus_ack     (bus_ack),
    .flush       (flush),
    .ram_addr    (ram_addr),
    .ram_req     (ram_req),
    .ram_ack     (ram_ack),
    .ram_data    (ram_data),
    .ram_valid   (ram_valid),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset_n && bus_ack) begin
      check("ack_single_pulse", 32'(prev_ack), 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: din 0x%0h with nothing expected", din);
      end else begin
        logic [15:0] exp;
        exp = exp_q.pop_front();
        if (din !== exp) begin
          errors++;
          $display("FAIL read_data: got 0x%0h expected 0x%0h", din, exp);
        end
      end
    end
    prev_ack = reset_n ? bus_ack : 1'b0;
  end

  // drivers: every task starts and ends 1 time unit after a rising edge
  task automatic hit_read(input logic [ADDR_W-1:0] a, input logic [15:0] exp, input bit guard);
    exp_q.push_back(exp);
    address = a;
    as = 1'b1;
    @(negedge clk); check("hit_pre_ack", 32'(bus_ack), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("hit_ack", 32'(bus_ack), 32'd1);
    check("hit_no_req", 32'(ram_req), 32'd0);
    if (guard) check("guard_acked_state", 32'(dbg_state), 32'(ST_ACKED));
    @(posedge clk); #1;
    as = 1'b0;
    if (guard) begin
      @(negedge clk);
      check("guard_no_second_ack", 32'(bus_ack), 32'd0);
      check("guard_idle_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      check("guard_no_late_ack", 32'(bus_ack), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic run_miss(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] base,
                          input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] b2, input logic [15:0] b3,
                          input logic [15:0] exp, input int ack_delay,
                          input bit flush_first, input bit flush_mid);
    logic [15:0] beats[4];
    beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
    exp_q.push_back(exp);
    address = a;
    as = 1'b1;
    flush = flush_first;
    @(negedge clk); check("miss_req_pre", 32'(ram_req), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      @(negedge clk); check("miss_req_hold", 32'(ram_req), 32'd1);
      @(posedge clk); #1;
    end
    ram_ack = 1'b1;
    ram_valid = 1'b1;
    ram_data = beats[0];
    @(negedge clk);
    check("miss_req", 32'(ram_req), 32'd1);
    check("miss_addr", 32'(ram_addr), 32'(base));
    for (int i = 1; i < 4; i++) begin
      @(posedge clk); #1;
      ram_ack = 1'b0;
      if (flush_mid && i == 2) begin
        ram_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end
      ram_valid = 1'b1;
      ram_data = beats[i];
      @(negedge clk);
      if (i == 1) check("miss_req_drop", 32'(ram_req), 32'd0);
    end
    @(posedge clk); #1;
    ram_valid = 1'b0;
    @(negedge clk); check("miss_ack_early", 32'(bus_ack), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); check("miss_ack", 32'(bus_ack), 32'd1);
    @(posedge clk); #1;
    as = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_ack", 32'(bus_ack), 32'd0);
    check("rst_din", 32'(din), 32'd0);
    check("rst_ram_req", 32'(ram_req), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // cold miss, then sequential hits in the same line
    run_miss(22'h076370, 22'h076370, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 2, 0, 0);
    hit_read(22'h076372, 16'h2222, 0);
    hit_read(22'h076374, 16'h3333, 0);
    hit_read(22'h076376, 16'h4444, 0);

    // stray beat while idle must not disturb the line
    ram_valid = 1'b1;
    ram_data = 16'hDEAD;
    @(posedge clk); #1;
    ram_valid = 1'b0;
    hit_read(22'h076370, 16'h1111, 0);

    // line crossing evicts the single line
    run_miss(22'h076378, 22'h076378, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h5555, 0, 0, 0);
    run_miss(22'h076370, 22'h076370, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111, 1, 0, 0);

    // as held through the ack cycle
    hit_read(22'h076374, 16'h3333, 1);

    // flush coinciding with a hit lookup turns it into a miss
    run_miss(22'h076376, 22'h076370, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h4444, 0, 1, 0);
    hit_read(22'h076370, 16'h1111, 0);

    // flush during fill: answered from beat 0, line left invalid
    run_miss(22'h000100, 22'h000100, 16'hA0A0, 16'hA1A1, 16'hA2A2, 16'hA3A3, 16'hA0A0, 1, 0, 1);
    run_miss(22'h000100, 22'h000100, 16'hB0B0, 16'hB1B1, 16'hB2B2, 16'hB3B3, 16'hB0B0, 0, 0, 0);

    // asynchronous reset after beat 1 of a burst
    address = 22'h001234;
    as = 1'b1;
    @(posedge clk); #1;
    ram_ack = 1'b1;
    ram_valid = 1'b1;
    ram_data = 16'hDEAD;
    @(posedge clk); #1;
    ram_ack = 1'b0;
    ram_data = 16'hBEEF;
    @(posedge clk); #1;
    ram_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ram_req", 32'(ram_req), 32'd0);
    check("arst_bus_ack", 32'(bus_ack), 32'd0);
    check("arst_ram_addr", 32'(ram_addr), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    as = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_miss(22'h001234, 22'h001230, 16'hC0C0, 16'hC1C1, 16'hC2C2, 16'hC3C3, 16'hC2C2, 1, 0, 0);

    repeat (4) @(posedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
